// File: rtl/alu_iter_if.sv
// rtl/alu_iter_if.sv - request/result handshake bundle for alu_iter
interface alu_iter_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, alu_ctl, in1, in2, out_ready,
    input  in_ready, out_valid, out, zero, illegal
  );

  modport slave (
    input  in_valid, alu_ctl, in1, in2, out_ready,
    output in_ready, out_valid, out, zero, illegal
  );
endinterface

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - registered ALU with iterative shift-add multiply and restoring divide
// Define ALU_ITER_DIV_EN to include the divider (divu/remu); otherwise those opcodes flag illegal.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  alu_iter_if.slave bus
);
  localparam int SHW   = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_MUL   = 4'b0100;
  localparam logic [3:0] OP_MULHU = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_SGEU  = 4'b1000;
  localparam logic [3:0] OP_SLL   = 4'b1001;
  localparam logic [3:0] OP_SRL   = 4'b1010;
  localparam logic [3:0] OP_SRA   = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_REMU  = 4'b1110;
  localparam logic [3:0] OP_SNE   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [3:0]         op_q;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   out_q;
  logic               zero_q;
  logic               illegal_q;

  logic               accept;
  logic               in_is_div;
  logic               is_iter;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_illegal;
  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [2*WIDTH-1:0] step_nxt;
  logic [WIDTH-1:0]   iter_res;

  assign bus.in_ready  = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = out_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign shamt  = bus.in2[SHW-1:0];

`ifdef ALU_ITER_DIV_EN
  logic             op_is_div;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_trial;
  logic             div_neg;
  logic [WIDTH-1:0] div_rem;
  logic [2*WIDTH-1:0] div_nxt;

  assign in_is_div = (bus.alu_ctl == OP_DIVU) | (bus.alu_ctl == OP_REMU);
  assign op_is_div = (op_q == OP_DIVU) | (op_q == OP_REMU);

  // Upper half of acc is the partial remainder, lower half shifts dividend out / quotient in.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_trial = {1'b0, div_shift} - {2'b00, a_q};
  assign div_neg   = div_trial[WIDTH+1];
  assign div_rem   = div_neg ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
  assign div_nxt   = {div_rem, acc[WIDTH-2:0], ~div_neg};
  assign step_nxt  = op_is_div ? div_nxt : mul_nxt;
`else
  assign in_is_div = 1'b0;
  assign step_nxt  = mul_nxt;
`endif

  assign is_iter = (bus.alu_ctl == OP_MUL) | (bus.alu_ctl == OP_MULHU) | in_is_div;

  // Shift-add: add multiplicand into the high half, then shift the whole accumulator right.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

  assign iter_res = ((op_q == OP_MULHU) | (op_q == OP_REMU)) ? step_nxt[2*WIDTH-1:WIDTH]
                                                             : step_nxt[WIDTH-1:0];

  always_comb begin
    sc_res     = '0;
    sc_illegal = 1'b0;
    case (bus.alu_ctl)
      OP_AND:   sc_res = bus.in1 & bus.in2;
      OP_OR:    sc_res = bus.in1 | bus.in2;
      OP_ADD:   sc_res = bus.in1 + bus.in2;
      OP_XOR:   sc_res = bus.in1 ^ bus.in2;
      OP_SUB:   sc_res = bus.in1 - bus.in2;
      OP_NOR:   sc_res = ~(bus.in1 | bus.in2);
      OP_SLTU:  sc_res = WIDTH'(bus.in1 < bus.in2);
      OP_SGEU:  sc_res = WIDTH'(bus.in1 >= bus.in2);
      OP_SNE:   sc_res = WIDTH'(bus.in1 != bus.in2);
      OP_SLL:   sc_res = bus.in1 << shamt;
      OP_SRL:   sc_res = bus.in1 >> shamt;
      OP_SRA:   sc_res = $signed(bus.in1) >>> shamt;
      OP_DIVU,
      OP_REMU:  sc_illegal = 1'b1;
      default:  sc_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = is_iter ? BUSY : DONE;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        BUSY:    if (cnt == CNT_W'(1)) state_d = DONE;
        DONE:    if (bus.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= '0;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      out_q     <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else if (accept) begin
      op_q <= bus.alu_ctl;
      if (is_iter) begin
        cnt <= CNT_W'(WIDTH);
        a_q <= in_is_div ? bus.in2 : bus.in1;
        b_q <= bus.in2;
        acc <= in_is_div ? {{WIDTH{1'b0}}, bus.in1} : '0;
      end else begin
        out_q     <= sc_res;
        zero_q    <= ~|sc_res;
        illegal_q <= sc_illegal;
      end
    end else if (state_q == BUSY) begin
      cnt <= cnt - CNT_W'(1);
      acc <= step_nxt;
      b_q <= b_q >> 1;
      if (cnt == CNT_W'(1)) begin
        out_q     <= iter_res;
        zero_q    <= ~|iter_res;
        illegal_q <= 1'b0;
      end
    end
  end
endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised successor to the single-cycle datapath ALU: registered-output ALU with a valid/ready handshake plus an iterative shift-add multiplier and restoring divider.
- Sits in the EX stage.
- The pipeline stalls EX while in_ready or out_valid is low.
- Opcodes 0000–1111 keep the existing ALU_ctl encodings; the spare codes carry the new operations.

Parameters:
- WIDTH, 32, operand/result width; power of two, 8..64.
- SHW, $clog2(WIDTH), shift-amount bits taken from in2[SHW-1:0]; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request this cycle.
- alu_ctl  input  4  opcode.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- out_valid  output  1  result is held valid.
- out_ready  input  1  consumer accepts the result.
- out  output  WIDTH  result.
- zero  output  1  ~|out, registered with out.
- illegal  output  1  opcode not supported in this build; qualified by out_valid.

Behaviour:
- Reset: one clock, synchronous, active-low. Takes effect on a clk edge with rst_n=0.
  - state=IDLE, out=0, zero=1, out_valid=0, illegal=0, iteration counter=0.
- Reset mid-operation abandons the operation; no result is produced.
- Operations (all unsigned unless stated):
  - 0000 and; 0001 or; 0010 add; 0110 sub; 0011 xor; 1100 nor.
  - 0111 sltu; 1000 sgeu; 1111 sne.
  - 1001 sll; 1010 srl; 1011 sra (arithmetic).
  - 0100 mul (low WIDTH bits); 0101 mulhu (high WIDTH bits).
  - 1101 divu; 1110 remu.
  - Comparison ops return 1 or 0 zero-extended to WIDTH.
  - add/sub wrap modulo 2^WIDTH.
  - Shift amount is in2[SHW-1:0].
- Accept rule: accept = in_valid & in_ready. Operands and opcode are captured on the accept edge; inputs are don't-care afterwards.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Back-to-back accept is allowed in the same cycle as result consumption.
- State machine:
  - IDLE --accept single-cycle op--> DONE. Result is registered on the accept edge, so out_valid=1 one cycle after accept.
  - IDLE --accept mul/mulhu/divu/remu--> BUSY. Counter is loaded with WIDTH.
  - BUSY: one iteration per clock.
    - Multiply: one bit of in2 per clock, LSB first, into a 2*WIDTH accumulator.
    - Divide: one quotient bit per clock, MSB first, restoring.
    - When the counter reaches 0 after WIDTH iterations --> DONE. out_valid=1 exactly WIDTH+1 cycles after accept.
  - DONE: out, zero and illegal are held stable while out_valid=1 & out_ready=0.
    - out_ready=1 with no accept --> IDLE.
    - out_ready=1 with an accept --> next op, per the IDLE rules above.
- Divide by zero (in2=0), not a special state; still takes WIDTH+1 cycles:
  - divu returns all-ones.
  - remu returns in1.
- mulhu with in1=0 or in2=0 returns 0 and still takes WIDTH+1 cycles; there is no early-out.
- in_valid while BUSY is ignored (in_ready=0). The requester must hold it.
- out_valid deasserts only on a consume or reset; no result is ever dropped or duplicated.

Optional Feature:
- Macro: ALU_ITER_DIV_EN.
- Defined: divu/remu behave as above; divider datapath is present.
- Undefined: divider logic is omitted.
  - 1101/1110 are handled as single-cycle ops: out=0, zero=1, illegal=1, out_valid one cycle after accept.
  - All other opcodes are unchanged; illegal is always 0 for them.

Test Plan:
- Reset, then add in1=0xFFFFFFFF, in2=1 with out_ready=1 -> out_valid exactly one cycle after accept, out=0, zero=1; sub 5-7 -> 0xFFFFFFFE.
- sra in1=0x80000000, in2=0x00000024 (amount 4) -> out=0xF8000000; srl of the same -> 0x08000000; sltu 3<5 -> 1.
- mul in1=0x00010000, in2=0x00010000 -> in_ready=0 for 32 cycles, out_valid at accept+33, out=0; mulhu with the same operands -> 0x00000001.
- divu 100/7 -> 14; remu 100/7 -> 2; divu 9/0 -> 0xFFFFFFFF; remu 9/0 -> 9. With ALU_ITER_DIV_EN undefined: divu -> out=0, illegal=1 after 1 cycle.
- Hold out_ready=0 for 5 cycles in DONE -> out and zero stable, in_ready=0. Then pulse out_ready=1 together with a new and-op -> both complete; the new result appears the next cycle.
- Drop rst_n for one edge mid-mul at iteration 10 -> out_valid=0, out=0, in_ready=1 next cycle; a fresh add then completes normally.
